serial_frame_tx: RTL and testbench



---
 rtl/serial_frame_tx_pkg.sv | 23 ++
 rtl/serial_frame_tx_if.sv | 29 ++
 rtl/serial_frame_tx_fifo.sv | 55 +++++
 rtl/serial_frame_tx.sv | 121 ++++++++++++
 tb/tb_serial_frame_tx.sv | 218 +++++++++++++++++++++
 5 files changed

// File: rtl/serial_frame_tx_pkg.sv
// rtl/serial_frame_tx_pkg.sv - shared constants, FSM encoding and parity helper
package serial_frame_tx_pkg;

  localparam int DATA_WIDTH_DEF = 8;

  localparam logic PAR_EVEN = 1'b0;
  localparam logic PAR_ODD  = 1'b1;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_START  = 3'd1,
    ST_DATA   = 3'd2,
    ST_PARITY = 3'd3,
    ST_STOP   = 3'd4,
    ST_GAP    = 3'd5
  } tx_state_t;

  // data_xor is the XOR of all payload bits; odd parity inverts it
  function automatic logic parity_bit(input logic data_xor, input logic typ);
    return data_xor ^ (typ == PAR_ODD);
  endfunction

endpackage

// File: rtl/serial_frame_tx_if.sv
// rtl/serial_frame_tx_if.sv - result input handshake and serial output bundle
interface serial_frame_tx_if
  import serial_frame_tx_pkg::*;
#(
  parameter int DATA_WIDTH = DATA_WIDTH_DEF,
  parameter int FIFO_DEPTH = 4
);

  logic [DATA_WIDTH-1:0]       IN_DATA;
  logic                        IN_VALID;
  logic                        IN_READY;
  logic                        PAR_EN;
  logic                        PAR_TYP;
  logic                        SYS_OUT;
  logic                        SYS_VLD;
  logic                        FRAME_DONE;
  logic [$clog2(FIFO_DEPTH):0] FIFO_COUNT;

  modport master (
    output IN_DATA, IN_VALID, PAR_EN, PAR_TYP,
    input  IN_READY, SYS_OUT, SYS_VLD, FRAME_DONE, FIFO_COUNT
  );

  modport slave (
    input  IN_DATA, IN_VALID, PAR_EN, PAR_TYP,
    output IN_READY, SYS_OUT, SYS_VLD, FRAME_DONE, FIFO_COUNT
  );

endinterface

// File: rtl/serial_frame_tx_fifo.sv
// rtl/serial_frame_tx_fifo.sv - tx_sync_fifo, count-based synchronous FIFO with fall-through head
module tx_sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     push,
  input  logic [WIDTH-1:0]         wdata,
  input  logic                     pop,
  output logic [WIDTH-1:0]         rdata,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] DEPTH_C = (AW+1)'(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic             do_push;
  logic             do_pop;

  assign full    = (count == DEPTH_C);
  assign empty   = (count == '0);
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign rdata   = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (do_push) begin
      mem[wr_ptr] <= wdata;
    end
  end

  // Pointers wrap naturally because DEPTH is a power of two
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/serial_frame_tx.sv
// rtl/serial_frame_tx.sv - buffered serial frame transmitter (start, LSB-first data, parity, stop)
module serial_frame_tx
  import serial_frame_tx_pkg::*;
#(
  parameter int DATA_WIDTH = DATA_WIDTH_DEF,
  parameter int FIFO_DEPTH = 4
) (
  input  logic             CLK,
  input  logic             RST,
  serial_frame_tx_if.slave bus
);

  localparam int CW = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;
  localparam logic [CW-1:0] LAST_BIT = CW'(DATA_WIDTH - 1);

  tx_state_t             state;
  logic [DATA_WIDTH-1:0] shift;
  logic [CW-1:0]         bit_cnt;
  logic                  par_en_q;
  logic                  par_bit_q;
  logic                  sys_out_q;
  logic                  sys_vld_q;
  logic                  frame_done_q;

  logic [DATA_WIDTH-1:0] fifo_rdata;
  logic                  fifo_full;
  logic                  fifo_empty;
  logic                  fifo_pop;

  assign fifo_pop = (state == ST_IDLE) && !fifo_empty;

  tx_sync_fifo #(
    .WIDTH (DATA_WIDTH),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk   (CLK),
    .rst_n (RST),
    .push  (bus.IN_VALID),
    .wdata (bus.IN_DATA),
    .pop   (fifo_pop),
    .rdata (fifo_rdata),
    .full  (fifo_full),
    .empty (fifo_empty),
    .count (bus.FIFO_COUNT)
  );

  assign bus.IN_READY   = !fifo_full;
  assign bus.SYS_OUT    = sys_out_q;
  assign bus.SYS_VLD    = sys_vld_q;
  assign bus.FRAME_DONE = frame_done_q;

  // state names the bit currently on the line; each edge registers the next bit
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      state        <= ST_IDLE;
      shift        <= '0;
      bit_cnt      <= '0;
      par_en_q     <= 1'b0;
      par_bit_q    <= 1'b0;
      sys_out_q    <= 1'b1;
      sys_vld_q    <= 1'b0;
      frame_done_q <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (!fifo_empty) begin
            shift     <= fifo_rdata;
            par_en_q  <= bus.PAR_EN;
            par_bit_q <= parity_bit(^fifo_rdata, bus.PAR_TYP);
            sys_out_q <= 1'b0;
            sys_vld_q <= 1'b1;
            state     <= ST_START;
          end
        end
        ST_START: begin
          sys_out_q <= shift[0];
          shift     <= shift >> 1;
          bit_cnt   <= '0;
          state     <= ST_DATA;
        end
        ST_DATA: begin
          if (bit_cnt == LAST_BIT) begin
            if (par_en_q) begin
              sys_out_q <= par_bit_q;
              state     <= ST_PARITY;
            end else begin
              sys_out_q    <= 1'b1;
              frame_done_q <= 1'b1;
              state        <= ST_STOP;
            end
          end else begin
            sys_out_q <= shift[0];
            shift     <= shift >> 1;
            bit_cnt   <= bit_cnt + 1'b1;
          end
        end
        ST_PARITY: begin
          sys_out_q    <= 1'b1;
          frame_done_q <= 1'b1;
          state        <= ST_STOP;
        end
        ST_STOP: begin
          sys_out_q    <= 1'b1;
          sys_vld_q    <= 1'b0;
          frame_done_q <= 1'b0;
          state        <= ST_GAP;
        end
        ST_GAP: begin
          state <= ST_IDLE;
        end
        default: begin
          sys_out_q    <= 1'b1;
          sys_vld_q    <= 1'b0;
          frame_done_q <= 1'b0;
          state        <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_serial_frame_tx.sv
// tb/tb_serial_frame_tx.sv - scoreboard bench for serial_frame_tx
module tb_serial_frame_tx;

  logic clk;
  logic rst_n;
  int   n_tests;
  int   n_fail;

  logic [1:0] exp_q[$];   // {line bit, frame_done}
  logic       mon_en;
  logic       check_gap;
  logic       vld_prev;
  logic       seen_done;
  int         low_run;

  serial_frame_tx_if bus ();

  serial_frame_tx dut (
    .CLK (clk),
    .RST (rst_n),
    .bus (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    n_tests++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got %0h required %0h at %0t", name, act, req, $time);
    end
  endtask

  // seq is written in transmission order, first bit leftmost
  task automatic exp_seq(input logic [15:0] seq, input int len);
    for (int i = 0; i < len; i++) begin
      exp_q.push_back({seq[len-1-i], (i == len-1) ? 1'b1 : 1'b0});
    end
  endtask

  task automatic exp_word(input logic [7:0] d, input logic en, input logic typ);
    exp_q.push_back(2'b00);
    for (int i = 0; i < 8; i++) exp_q.push_back({d[i], 1'b0});
    if (en) exp_q.push_back({(^d) ^ typ, 1'b0});
    exp_q.push_back(2'b11);
  endtask

  task automatic push(input logic [7:0] d);
    bus.IN_DATA  = d;
    bus.IN_VALID = 1'b1;
    @(posedge clk);
    #1;
    bus.IN_VALID = 1'b0;
  endtask

  task automatic drain();
    int t;
    t = 0;
    while ((exp_q.size() != 0 || bus.SYS_VLD || bus.FIFO_COUNT != 0) && t < 400) begin
      @(negedge clk);
      t++;
    end
    chk("drain_timeout", 32'(t < 400), 1);
    repeat (15) @(negedge clk);
    chk("leftover_expected", exp_q.size(), 0);
  endtask

  // Monitor: every SYS_VLD cycle must match the head of the scoreboard
  always @(negedge clk) begin
    logic [1:0] e;
    if (mon_en) begin
      if (bus.SYS_VLD) begin
        if (!vld_prev && check_gap && seen_done) chk("gap_len", low_run, 2);
        low_run = 0;
        if (exp_q.size() == 0) begin
          chk("unexpected_bit", 32'(bus.SYS_VLD), 0);
        end else begin
          e = exp_q.pop_front();
          chk("frame_bit", {30'd0, bus.SYS_OUT, bus.FRAME_DONE}, {30'd0, e});
        end
        if (bus.FRAME_DONE) seen_done = 1'b1;
      end else begin
        if (vld_prev) chk("idle_line", {30'd0, bus.SYS_OUT, bus.FRAME_DONE}, 32'h2);
        low_run++;
        if (low_run > 10) seen_done = 1'b0;
      end
      vld_prev = bus.SYS_VLD;
    end
  end

  initial begin
    logic [7:0] burst [5];
    int exp_cnt [5];
    int vcount;
    int t;
    burst   = '{8'h11, 8'h22, 8'h3C, 8'h80, 8'hE7};
    exp_cnt = '{1, 1, 2, 3, 4};
    n_tests = 0;
    n_fail = 0;
    mon_en = 1'b0;
    check_gap = 1'b0;
    vld_prev = 1'b0;
    seen_done = 1'b0;
    low_run = 0;
    rst_n = 1'b0;
    bus.IN_DATA = '0;
    bus.IN_VALID = 1'b0;
    bus.PAR_EN = 1'b0;
    bus.PAR_TYP = 1'b0;

    repeat (2) @(posedge clk);
    #1;
    chk("rst_sys_out", 32'(bus.SYS_OUT), 1);
    chk("rst_sys_vld", 32'(bus.SYS_VLD), 0);
    chk("rst_frame_done", 32'(bus.FRAME_DONE), 0);
    chk("rst_in_ready", 32'(bus.IN_READY), 1);
    chk("rst_fifo_count", 32'(bus.FIFO_COUNT), 0);
    @(negedge clk);
    rst_n = 1'b1;
    mon_en = 1'b1;

    // Even parity, 0xA5
    @(negedge clk);
    bus.PAR_EN = 1'b1;
    bus.PAR_TYP = 1'b0;
    exp_seq(16'b01010010101, 11);
    push(8'hA5);
    drain();

    // Odd parity, 0x07
    @(negedge clk);
    bus.PAR_TYP = 1'b1;
    exp_seq(16'b01110000001, 11);
    push(8'h07);
    drain();

    // No parity, 0xFF, plus pop/start-bit latency
    @(negedge clk);
    bus.PAR_EN = 1'b0;
    exp_seq(16'b0111111111, 10);
    push(8'hFF);
    chk("lat_count_after_push", 32'(bus.FIFO_COUNT), 1);
    chk("lat_vld_at_push", 32'(bus.SYS_VLD), 0);
    @(posedge clk);
    #1;
    chk("lat_start_vld", 32'(bus.SYS_VLD), 1);
    chk("lat_start_bit", 32'(bus.SYS_OUT), 0);
    chk("lat_count_after_pop", 32'(bus.FIFO_COUNT), 0);
    drain();

    // Burst of five, then a dropped push while full
    @(negedge clk);
    bus.PAR_EN = 1'b1;
    bus.PAR_TYP = 1'b1;
    check_gap = 1'b1;
    for (int i = 0; i < 5; i++) begin
      exp_word(burst[i], 1'b1, 1'b1);
      push(burst[i]);
      chk("burst_count", 32'(bus.FIFO_COUNT), 32'(exp_cnt[i]));
    end
    chk("full_in_ready", 32'(bus.IN_READY), 0);
    push(8'h66);
    chk("full_drop_count", 32'(bus.FIFO_COUNT), 4);
    drain();
    check_gap = 1'b0;

    // PAR_EN change mid-frame affects only the next frame
    @(negedge clk);
    bus.PAR_EN = 1'b1;
    bus.PAR_TYP = 1'b0;
    exp_seq(16'b00101101001, 11);
    push(8'h5A);
    exp_seq(16'b0110000111, 10);
    push(8'hC3);
    repeat (4) @(posedge clk);
    #1;
    bus.PAR_EN = 1'b0;
    drain();

    // Reset mid-frame with a second word still queued
    mon_en = 1'b0;
    @(negedge clk);
    bus.PAR_EN = 1'b1;
    bus.PAR_TYP = 1'b0;
    push(8'hA5);
    push(8'h3C);
    vcount = 0;
    t = 0;
    while (vcount < 4 && t < 50) begin
      @(negedge clk);
      t++;
      if (bus.SYS_VLD) vcount++;
    end
    chk("rst_mid_reached", 32'(vcount), 4);
    #2;
    rst_n = 1'b0;
    #1;
    chk("rst_mid_sys_out", 32'(bus.SYS_OUT), 1);
    chk("rst_mid_sys_vld", 32'(bus.SYS_VLD), 0);
    chk("rst_mid_fifo_count", 32'(bus.FIFO_COUNT), 0);
    chk("rst_mid_frame_done", 32'(bus.FRAME_DONE), 0);
    @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    vcount = 0;
    repeat (30) begin
      @(negedge clk);
      if (bus.SYS_VLD) vcount++;
    end
    chk("rst_mid_no_frame", 32'(vcount), 0);
    chk("rst_mid_count_after", 32'(bus.FIFO_COUNT), 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
